// File: rtl/multicycle_chunk_adder.sv
// ---------------------------------------------------------------------------
// multicycle_chunk_adder
//
// Purpose:
//    Multi-cycle adder that computes S = A + B + Cin over WIDTH bits by adding
//    one CHUNK-bit slice per clock, least significant slice first. The carry
//    between slices lives in a register, so only a CHUNK-bit adder is built.
//    Operands are taken with a valid/ready handshake. The result is held with
//    out_valid until the consumer takes it with out_ready.
//
// Parameters:
//    WIDTH  operand/result width; must be a multiple of CHUNK
//    CHUNK  bits added per cycle; WIDTH/CHUNK must be at least 2
//
// Optional feature:
//    ADDSUB_EN  when defined, adds the Sub port. With Sub=1 the block latches
//               ~B and forces the carry-in to 1, giving S = A - B.
//
// Ports:
//    clk        rising-edge clock
//    rst        synchronous reset, active-high
//    in_valid   operands A/B/Cin (and Sub) are valid
//    in_ready   block can accept operands (IDLE only)
//    A, B       WIDTH-bit operands
//    Cin        carry into bit 0
//    Sub        subtract select (ADDSUB_EN builds only)
//    out_valid  S/Cout/V hold a finished result
//    out_ready  consumer accepts the result
//    S          WIDTH-bit sum
//    Cout       carry out of bit WIDTH-1
//    V          two's-complement overflow
// ---------------------------------------------------------------------------
module multicycle_chunk_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef ADDSUB_EN
   input  logic             Sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Refuse to build a configuration the slice counter cannot handle.
   // Uneven slicing would leave the top bits unadded, and a single slice
   // would make the multi-cycle machinery pointless.
   generate
      if ((WIDTH % CHUNK) != 0 || (WIDTH / CHUNK) < 2) begin : g_bad_params
         $error("multicycle_chunk_adder: WIDTH must be a multiple of CHUNK with WIDTH/CHUNK >= 2");
      end
   endgenerate

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic             carry;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [CHUNK:0]   slice_sum;
   logic [WIDTH-1:0] b_eff;
   logic             carry_in;

   // Operand conditioning at accept time. Subtraction is A + ~B + 1, so the
   // inverted operand and the forced carry are latched once. The slice loop
   // then never needs to know which operation is running.
`ifdef ADDSUB_EN
   always_comb begin
      b_eff    = Sub ? ~B : B;
      carry_in = Sub ? 1'b1 : Cin;
   end
`else
   always_comb begin
      b_eff    = B;
      carry_in = Cin;
   end
`endif

   // The one physical CHUNK-bit adder. It works on the slice that count
   // selects. The extra top bit is the carry into the next slice.
   always_comb begin
      slice_sum = {1'b0, a_reg[int'(count)*CHUNK +: CHUNK]}
                + {1'b0, b_reg[int'(count)*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry};
   end

   // The handshake outputs come straight from the state. in_ready therefore
   // falls on the accept edge, and out_valid rises with the final slice.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Main sequencer. IDLE latches the operands, RUN adds one slice per clock,
   // and DONE holds the result until the consumer takes it. Reset aborts an
   // operation at any point, so a result is never produced. Overflow is
   // judged from the operand sign bits and the sign bit of the top slice
   // being written on the final edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         carry <= 1'b0;
         a_reg <= '0;
         b_reg <= '0;
         S     <= '0;
         Cout  <= 1'b0;
         V     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= A;
                  b_reg <= b_eff;
                  carry <= carry_in;
                  count <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               S[int'(count)*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
               carry <= slice_sum[CHUNK];
               count <= count + 1'b1;
               if (count == LAST) begin
                  Cout  <= slice_sum[CHUNK];
                  V     <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (slice_sum[CHUNK-1] != a_reg[WIDTH-1]);
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_multicycle_chunk_adder
//
// Purpose:
//    Directed bench for multicycle_chunk_adder at WIDTH=64, CHUNK=16.
//    The stimulus pushes hand-computed results into a scoreboard queue. A
//    separate monitor pops the queue and compares each result the DUT
//    presents. The stimulus thread also checks latency, result hold,
//    handshake and reset abort directly. Define ADDSUB_EN to add the
//    subtract vectors.
// ---------------------------------------------------------------------------
module tb_multicycle_chunk_adder;

   typedef struct {
      logic [63:0] s;
      logic        cout;
      logic        v;
   } result_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] A;
   logic [63:0] B;
   logic        Cin;
`ifdef ADDSUB_EN
   logic        Sub;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [63:0] S;
   logic        Cout;
   logic        V;

   result_t     sb[$];
   int          checks;
   int          errors;
   bit          seen;

   multicycle_chunk_adder #(.WIDTH(64), .CHUNK(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
`ifdef ADDSUB_EN
      .Sub       (Sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
      .V         (V)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, and reports it when actual differs from required.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%016h required=0x%016h", name, act, exp);
      end
   endtask

   // Monitor: compare once per presented result, on the falling edge, against
   // the oldest entry that the stimulus queued.
   always @(negedge clk) begin
      if (rst || !out_valid) begin
         seen <= 1'b0;
      end else if (!seen) begin
         seen <= 1'b1;
         if (sb.size() == 0) begin
            checkOutput("unexpected_result", 64'(out_valid), 64'(1'b0));
         end else begin
            result_t e;
            e = sb.pop_front();
            checkOutput("sb_S", S, e.s);
            checkOutput("sb_Cout", 64'(Cout), 64'(e.cout));
            checkOutput("sb_V", 64'(V), 64'(e.v));
         end
      end
   end

   // Present one operand set and return just after the edge that accepts it.
   task automatic issueOp(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'(1'b1));
      A = a;
      B = b;
      Cin = cin;
`ifdef ADDSUB_EN
      Sub = sub;
`else
      if (sub) $display("[TB] note: sub vector skipped without ADDSUB_EN");
`endif
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Queue the expected result, issue the operation, and check that
   // out_valid appears exactly four edges after the accept edge.
   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                input logic sub, input logic [63:0] es, input logic ec, input logic ev);
      result_t r;
      int lat;
      r.s = es;
      r.cout = ec;
      r.v = ev;
      sb.push_back(r);
      issueOp(a, b, cin, sub);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency", 64'(lat), 64'd4);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      A = '0;
      B = '0;
      Cin = 1'b0;
`ifdef ADDSUB_EN
      Sub = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_S", S, 64'd0);
      checkOutput("reset_Cout", 64'(Cout), 64'd0);
      checkOutput("reset_V", 64'(V), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Carry ripples through every slice and wraps to zero.
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
      // Positive overflow into the sign bit.
      applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      // Carry from slice 0 into slice 1, with Cin used.
      applyStimulus(64'h0000_FFFF_0000_FFFF, 64'd1, 1'b1, 1'b0, 64'h0000_FFFF_0001_0001, 1'b0, 1'b0);
      // Negative overflow: the sum wraps to zero with a carry out.
      applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
      // Carries from three slices, with no final carry.
      applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0, 1'b0);

      // Hold test: the result must stay put under backpressure while new
      // operands are offered.
      @(posedge clk); #1;
      out_ready = 1'b0;
      applyStimulus(64'd100, 64'd23, 1'b0, 1'b0, 64'd123, 1'b0, 1'b0);
      A = 64'hDEAD;
      B = 64'hBEEF;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkOutput("hold_S", S, 64'd123);
         checkOutput("hold_Cout", 64'(Cout), 64'd0);
         checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
         checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("release_in_ready", 64'(in_ready), 64'd1);
      checkOutput("release_out_valid", 64'(out_valid), 64'd0);

      // Reset during the second RUN cycle aborts the operation. No result
      // is queued for it, so any output is reported as unexpected.
      issueOp(64'h1111, 64'h2222, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
      checkOutput("abort_S", S, 64'd0);
      checkOutput("abort_Cout", 64'(Cout), 64'd0);
      checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("abort_no_result", 64'(out_valid), 64'd0);
      applyStimulus(64'd2, 64'd3, 1'b0, 1'b0, 64'd5, 1'b0, 1'b0);

`ifdef ADDSUB_EN
      // Subtraction: a borrow gives Cout=0, and no borrow gives Cout=1.
      // Sub=0 must still add.
      applyStimulus(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      applyStimulus(64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
      applyStimulus(64'd7, 64'd5, 1'b1, 1'b0, 64'd13, 1'b0, 1'b0);
`endif

      repeat (4) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Backstop, so that a stalled run still ends with a report.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
